// File: rtl/cmpl_mul_pipe.sv
// Pipelined signed complex multiplier: A*B or A*conj(B), with round-half-up scaling,
// saturation, per-stage valid tracking and a global clock enable.

module cmpl_mul_rsat #(
    parameter int P     = 37,
    parameter int OW    = 18,
    parameter int SHIFT = 17
) (
    input  logic signed [P-1:0]  din,
    output logic signed [OW-1:0] dout,
    output logic                 ovf
);
    // One guard bit so the rounding add can never wrap.
    localparam int R  = P + 1;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [R-1:0] RND  = (SHIFT > 0) ? (R'(1) << RS) : '0;
    localparam logic signed [R-1:0] SMAX = $signed({{(R-OW+1){1'b0}}, {(OW-1){1'b1}}});
    localparam logic signed [R-1:0] SMIN = ~SMAX;

    logic signed [R-1:0] rnd;
    logic signed [R-1:0] shf;

    always_comb begin
        rnd  = {din[P-1], din} + RND;
        shf  = rnd >>> SHIFT;
        ovf  = 1'b0;
        dout = shf[OW-1:0];
        if (shf > SMAX) begin
            ovf  = 1'b1;
            dout = SMAX[OW-1:0];
        end else if (shf < SMIN) begin
            ovf  = 1'b1;
            dout = SMIN[OW-1:0];
        end
    end
endmodule

module cmpl_mul_pipe #(
    parameter int DW      = 18,
    parameter int OW      = 18,
    parameter int SHIFT   = 17,
    parameter int LATENCY = 6
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 in_valid,
    input  logic                 conj,
    input  logic signed [DW-1:0] a_real,
    input  logic signed [DW-1:0] a_imag,
    input  logic signed [DW-1:0] b_real,
    input  logic signed [DW-1:0] b_imag,
    output logic                 out_valid,
    output logic signed [OW-1:0] out_real,
    output logic signed [OW-1:0] out_imag,
    output logic                 out_ovf
);
    localparam int PW = 2 * DW;
    localparam int P  = 2 * DW + 1;

    typedef struct packed {
        logic signed [OW-1:0] re;
        logic signed [OW-1:0] im;
        logic                 ovf;
    } res_t;

    logic [LATENCY:1]     vld_pipe;
    logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
    logic                 conj_s1;
    logic [1:0][P-1:0]    sum_q;
    logic [1:0][OW-1:0]   rs_d;
    logic [1:0]           rs_ovf;
    res_t                 rs_in;
    res_t                 final_d;
    res_t                 res_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            vld_pipe <= '0;
        else if (ce)
            vld_pipe <= {vld_pipe[LATENCY-1:1], in_valid};
    end

    // Stage 1: four partial products at full 2*DW precision.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p_rr    <= '0;
            p_ii    <= '0;
            p_ri    <= '0;
            p_ir    <= '0;
            conj_s1 <= 1'b0;
        end else if (ce) begin
            p_rr    <= PW'(a_real) * PW'(b_real);
            p_ii    <= PW'(a_imag) * PW'(b_imag);
            p_ri    <= PW'(a_real) * PW'(b_imag);
            p_ir    <= PW'(a_imag) * PW'(b_real);
            conj_s1 <= conj;
        end
    end

    // Stage 2: sums in P bits so the (-2^(DW-1))^2 * 2 corner stays exact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (ce) begin
            sum_q[0] <= conj_s1 ? P'(p_rr) + P'(p_ii) : P'(p_rr) - P'(p_ii);
            sum_q[1] <= conj_s1 ? P'(p_ir) - P'(p_ri) : P'(p_ri) + P'(p_ir);
        end
    end

    // Stage 3 logic: one round/saturate unit per component.
    cmpl_mul_rsat #(.P(P), .OW(OW), .SHIFT(SHIFT)) u_rs [1:0] (
        .din  (sum_q),
        .dout (rs_d),
        .ovf  (rs_ovf)
    );

    always_comb begin
        rs_in.re  = rs_d[0];
        rs_in.im  = rs_d[1];
        rs_in.ovf = |rs_ovf;
    end

    generate
        if (LATENCY == 3) begin : g_nodly
            assign final_d = rs_in;
        end else begin : g_dly
            res_t dly [3:LATENCY-1];
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    for (int k = 3; k < LATENCY; k++)
                        dly[k] <= '0;
                end else if (ce) begin
                    dly[3] <= rs_in;
                    for (int k = 4; k < LATENCY; k++)
                        dly[k] <= dly[k-1];
                end
            end
            assign final_d = dly[LATENCY-1];
        end
    endgenerate

    // Output register only captures valid results, so it holds between them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            res_q <= '0;
        else if (ce && vld_pipe[LATENCY-1])
            res_q <= final_d;
    end

    assign out_valid = vld_pipe[LATENCY];
    assign out_real  = res_q.re;
    assign out_imag  = res_q.im;
    assign out_ovf   = res_q.ovf;
endmodule

// File: tb/tb_cmpl_mul_pipe.sv
// Directed and constrained-random checks for cmpl_mul_pipe at DW=OW=18, SHIFT=17, LATENCY=6.

module tb_cmpl_mul_pipe;
    localparam int DW = 18, OW = 18, SHIFT = 17, LATENCY = 6;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0, in_valid = 1'b0, conj = 1'b0;
    logic signed [DW-1:0] a_real = '0, a_imag = '0, b_real = '0, b_imag = '0;
    logic                 out_valid;
    logic signed [OW-1:0] out_real, out_imag;
    logic                 out_ovf;

    int n_chk = 0;
    int n_err = 0;

    cmpl_mul_pipe #(.DW(DW), .OW(OW), .SHIFT(SHIFT), .LATENCY(LATENCY)) dut (
        .clock(clock), .reset(reset), .ce(ce), .in_valid(in_valid), .conj(conj),
        .a_real(a_real), .a_imag(a_imag), .b_real(b_real), .b_imag(b_imag),
        .out_valid(out_valid), .out_real(out_real), .out_imag(out_imag), .out_ovf(out_ovf)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_ops(input int ar, input int ai, input int br, input int bi, input bit cj);
        a_real = 18'(ar); a_imag = 18'(ai);
        b_real = 18'(br); b_imag = 18'(bi);
        conj   = cj;
    endtask

    // One sample in, output expected exactly LATENCY enabled edges later.
    task automatic run_one(input string tag, input int ar, input int ai, input int br, input int bi,
                           input bit cj, input int er, input int ei, input bit eo);
        set_ops(ar, ai, br, bi, cj);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (LATENCY - 2) tick();
        chk({tag, "_early"}, out_valid, 0);
        tick();
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_re"}, out_real, er);
        chk({tag, "_im"}, out_imag, ei);
        chk({tag, "_ovf"}, out_ovf, eo);
    endtask

    function automatic logic [36:0] model(input longint ar, input longint ai, input longint br,
                                          input longint bi, input bit cj);
        longint p [2];
        longint s;
        logic [17:0] o [2];
        bit ov = 1'b0;
        p[0] = cj ? ar*br + ai*bi : ar*br - ai*bi;
        p[1] = cj ? ai*br - ar*bi : ar*bi + ai*br;
        for (int c = 0; c < 2; c++) begin
            s = (p[c] + 65536) >>> 17;
            if (s > 131071) begin s = 131071; ov = 1'b1; end
            else if (s < -131072) begin s = -131072; ov = 1'b1; end
            o[c] = 18'(s);
        end
        return {ov, o[0], o[1]};
    endfunction

    int r_ar, r_ai, r_br, r_bi, sent, n_out, cyc, vcount;
    bit r_cj, ce_was, pv;
    logic [36:0] q [$];
    logic [36:0] pd, expv;

    function automatic int rnd_op();
        if ($urandom_range(0, 7) == 0) return -131072;
        return int'($urandom_range(0, 262143)) - 131072;
    endfunction

    initial begin
        // Reset state
        ce = 1'b1;
        repeat (2) tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_re", out_real, 0);
        chk("rst_im", out_imag, 0);
        chk("rst_ovf", out_ovf, 0);
        reset = 1'b0;
        tick();

        // Main function and boundaries
        run_one("mul",      65536, 65536, 65536, -65536, 1'b0, 65536, 0, 1'b0);
        run_one("conj",     65536, 65536, 65536, -65536, 1'b1, 0, 65536, 1'b0);
        run_one("sat_pos", -131072, 0, -131072, 0, 1'b0, 131071, 0, 1'b1);
        run_one("extreme", -131072, -131072, -131072, -131072, 1'b1, 131071, 0, 1'b1);
        run_one("sat_neg", -131072, 131071, 131071, 131071, 1'b0, -131072, -1, 1'b1);
        run_one("rnd_up",   1, 0, 65536, 0, 1'b0, 1, 0, 1'b0);
        run_one("rnd_dn",   1, 0, 65535, 0, 1'b0, 0, 0, 1'b0);
        run_one("rnd_neg", -1, 0, 65536, 0, 1'b0, 0, 0, 1'b0);
        run_one("rnd_neg1", -1, 0, 65537, 0, 1'b0, -1, 0, 1'b0);

        // Hold while out_valid=0
        repeat (3) tick();
        chk("hold_valid", out_valid, 0);
        chk("hold_re", out_real, -1);

        // Stall: disabled cycles do not count, in_valid ignored while ce=0
        set_ops(65536, 65536, 65536, -65536, 1'b0);
        in_valid = 1'b1;
        tick();
        ce = 1'b0;
        set_ops(1, 0, 65536, 0, 1'b0);
        repeat (3) tick();
        in_valid = 1'b0;
        ce = 1'b1;
        repeat (4) tick();
        ce = 1'b0;
        repeat (2) tick();
        chk("stall_early", out_valid, 0);
        ce = 1'b1;
        tick();
        chk("stall_valid", out_valid, 1);
        chk("stall_re", out_real, 65536);
        ce = 1'b0;
        repeat (3) tick();
        chk("stall_hold_v", out_valid, 1);
        chk("stall_hold_re", out_real, 65536);
        ce = 1'b1;
        vcount = 0;
        repeat (8) begin tick(); if (out_valid) vcount++; end
        chk("stall_ignored", vcount, 0);

        // Back-to-back random stream with random ce
        sent = 0; n_out = 0; cyc = 0;
        while ((sent < 100 || q.size() > 0) && cyc < 3000) begin
            ce = ($urandom_range(0, 3) != 0);
            in_valid = (sent < 100);
            r_ar = rnd_op(); r_ai = rnd_op(); r_br = rnd_op(); r_bi = rnd_op();
            r_cj = 1'($urandom_range(0, 1));
            set_ops(r_ar, r_ai, r_br, r_bi, r_cj);
            if (ce && in_valid) begin
                q.push_back(model(r_ar, r_ai, r_br, r_bi, r_cj));
                sent++;
            end
            ce_was = ce;
            pv = out_valid;
            pd = {out_ovf, out_real, out_imag};
            tick();
            cyc++;
            if (ce_was) begin
                if (out_valid) begin
                    if (q.size() == 0) chk("rnd_extra", 1, 0);
                    else begin
                        expv = q.pop_front();
                        chk("rnd_data", {out_ovf, out_real, out_imag}, expv);
                        n_out++;
                    end
                end
            end else begin
                chk("rnd_hold", {out_valid, out_ovf, out_real, out_imag}, {pv, pd});
            end
        end
        in_valid = 1'b0;
        ce = 1'b1;
        chk("rnd_count", n_out, 100);
        chk("rnd_timeout", cyc < 3000, 1);

        // Reset while samples are in flight
        set_ops(65536, 65536, 65536, -65536, 1'b0);
        in_valid = 1'b1;
        repeat (8) tick();
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_re", out_real, 0);
        chk("arst_ovf", out_ovf, 0);
        repeat (2) tick();
        reset = 1'b0;
        vcount = 0;
        repeat (12) begin tick(); if (out_valid) vcount++; end
        chk("no_stale", vcount, 0);
        run_one("post_rst", 1, 0, 65536, 0, 1'b0, 1, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
